// File: rtl/stage_sequencer.sv
// Stage sequencer for the five-stage multi-cycle CPU: one-hot stage enables on a single clock.
// Latency: PAUSE->F one cycle, then 5 cycles per instruction plus one per stalled M cycle.
// Backpressure: M holds while memory waits or a UART store meets a busy transmitter.
module stage_sequencer #(
  parameter int RET_CNT_W   = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   run_i,
  input  logic                   step_i,
  input  logic                   halt_i,
  input  logic                   mem_wait_i,
  input  logic                   uart_store_i,
  input  logic                   uart_busy_i,
  output logic                   fetch_en,
  output logic                   decode_en,
  output logic                   exec_en,
  output logic                   mem_en,
  output logic                   wb_en,
  output logic [2:0]             stage_o,
  output logic                   paused_o,
  output logic                   halted_o,
  output logic [RET_CNT_W-1:0]   retired_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [2:0] {
    ST_F     = 3'd0,
    ST_D     = 3'd1,
    ST_E     = 3'd2,
    ST_M     = 3'd3,
    ST_W     = 3'd4,
    ST_PAUSE = 3'd5,
    ST_HALT  = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic                   halt_pending_q, halt_pending_d;
  logic                   step_mode_q, step_mode_d;
  logic [RET_CNT_W-1:0]   retired_q, retired_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   mem_stall;

  // M cannot commit while data memory is busy or a UART store would overrun the transmitter
  assign mem_stall = mem_wait_i | (uart_store_i & uart_busy_i);

  // State register; reset parks the machine in PAUSE so every enable drops at once
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_PAUSE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control flags and debug/perf counters
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      halt_pending_q <= 1'b0;
      step_mode_q    <= 1'b0;
      retired_q      <= '0;
      stall_cnt_q    <= '0;
    end else begin
      halt_pending_q <= halt_pending_d;
      step_mode_q    <= step_mode_d;
      retired_q      <= retired_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  // Next-state: stages advance unconditionally except stalled M; W picks halt, pause or next fetch
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_F:     state_d = ST_D;
      ST_D:     state_d = ST_E;
      ST_E:     state_d = ST_M;
      ST_M:     if (!mem_stall) state_d = ST_W;
      ST_W: begin
        if (halt_pending_q) begin
          state_d = ST_HALT;
        end else if (step_mode_q || !run_i) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_F;
        end
      end
      ST_PAUSE: if (run_i || step_i) state_d = ST_F;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_PAUSE;
    endcase
  end

  // Next flag/counter values; counters wrap naturally at their width
  always_comb begin
    halt_pending_d = halt_pending_q;
    step_mode_d    = step_mode_q;
    retired_d      = retired_q;
    stall_cnt_d    = stall_cnt_q;

    if (state_q == ST_E && halt_i) begin
      halt_pending_d = 1'b1;
    end

    // A single-step instruction is retired at W; clearing here is harmless on the other W exits
    if (state_q == ST_W) begin
      step_mode_d = 1'b0;
      retired_d   = retired_q + RET_CNT_W'(1);
    end

    // run_i has priority over step_i, so step mode only arms when paused without run
    if (state_q == ST_PAUSE && !run_i && step_i) begin
      step_mode_d = 1'b1;
    end

    if (state_q == ST_M && mem_stall) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // Output decode from registered state; only mem_en also looks at the stall inputs
  always_comb begin
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    case (state_q)
      ST_F:    fetch_en  = 1'b1;
      ST_D:    decode_en = 1'b1;
      ST_E:    exec_en   = 1'b1;
      ST_M:    mem_en    = !mem_stall;
      ST_W:    wb_en     = 1'b1;
      default: ;
    endcase
    stage_o  = state_q;
    paused_o = (state_q == ST_PAUSE);
    halted_o = (state_q == ST_HALT);
  end

  assign retired_o      = retired_q;
  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus randomized run,
// compared every cycle against an instruction-level model kept in the bench.
module tb_stage_sequencer;
  localparam int RW = 4;
  localparam int SW = 6;

  logic          sysclk = 1'b0;
  logic          reset = 1'b0;
  logic          run_i = 1'b0;
  logic          step_i = 1'b0;
  logic          halt_i = 1'b0;
  logic          mem_wait_i = 1'b0;
  logic          uart_store_i = 1'b0;
  logic          uart_busy_i = 1'b0;
  logic          fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic [2:0]    stage_o;
  logic          paused_o, halted_o;
  logic [RW-1:0] retired_o;
  logic [SW-1:0] stall_cycles_o;

  stage_sequencer #(.RET_CNT_W(RW), .STALL_CNT_W(SW)) dut (
    .sysclk(sysclk), .reset(reset), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
    .mem_wait_i(mem_wait_i), .uart_store_i(uart_store_i), .uart_busy_i(uart_busy_i),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .mem_en(mem_en),
    .wb_en(wb_en), .stage_o(stage_o), .paused_o(paused_o), .halted_o(halted_o),
    .retired_o(retired_o), .stall_cycles_o(stall_cycles_o)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Instruction-level model: mode 0 = executing (phase 0..4 = F..W), 1 = paused, 2 = halted
  int m_mode  = 1;
  int m_phase = 0;
  bit m_halt  = 1'b0;
  bit m_step  = 1'b0;
  int m_ret   = 0;
  int m_stall = 0;

  function automatic bit stall_now();
    return mem_wait_i | (uart_store_i & uart_busy_i);
  endfunction

  always @(posedge sysclk or posedge reset) begin
    if (reset) begin
      m_mode = 1; m_phase = 0; m_halt = 1'b0; m_step = 1'b0; m_ret = 0; m_stall = 0;
    end else if (m_mode == 0) begin
      if (m_phase == 2) begin
        if (halt_i) m_halt = 1'b1;
        m_phase = 3;
      end else if (m_phase == 3) begin
        if (stall_now()) m_stall++;
        else m_phase = 4;
      end else if (m_phase == 4) begin
        m_ret++;
        if (m_halt) m_mode = 2;
        else if (m_step || !run_i) begin m_mode = 1; m_step = 1'b0; end
        else m_phase = 0;
      end else begin
        m_phase++;
      end
    end else if (m_mode == 1) begin
      if (run_i) begin m_mode = 0; m_phase = 0; end
      else if (step_i) begin m_mode = 0; m_phase = 0; m_step = 1'b1; end
    end
  end

  function automatic int exp_stage();
    if (m_mode == 2) return 6;
    if (m_mode == 1) return 5;
    return m_phase;
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge sysclk) begin
    chk("fetch_en",  32'(fetch_en),  32'(m_mode == 0 && m_phase == 0));
    chk("decode_en", 32'(decode_en), 32'(m_mode == 0 && m_phase == 1));
    chk("exec_en",   32'(exec_en),   32'(m_mode == 0 && m_phase == 2));
    chk("mem_en",    32'(mem_en),    32'(m_mode == 0 && m_phase == 3 && !stall_now()));
    chk("wb_en",     32'(wb_en),     32'(m_mode == 0 && m_phase == 4));
    chk("stage_o",   32'(stage_o),   exp_stage());
    chk("paused_o",  32'(paused_o),  32'(m_mode == 1));
    chk("halted_o",  32'(halted_o),  32'(m_mode == 2));
    chk("retired_o", 32'(retired_o), m_ret % (1 << RW));
    chk("stall_o",   32'(stall_cycles_o), m_stall % (1 << SW));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #2;
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    run_i = 1'b1;
    tick(2);
    #1;
    chk("rst_stage", 32'(stage_o), 5);
    chk("rst_paused", 32'(paused_o), 1);
    chk("rst_enables", 32'({fetch_en, decode_en, exec_en, mem_en, wb_en}), 0);
    chk("rst_retired", 32'(retired_o), 0);
    reset = 1'b0;

    // Free run, three instructions without stalls
    tick();
    #1 chk("first_fetch", 32'(fetch_en), 1);
    tick(15);
    #1;
    chk("run3_retired", 32'(retired_o), 3);
    chk("run3_model", m_ret, 3);
    chk("run3_stall", 32'(stall_cycles_o), 0);
    chk("run3_fetch", 32'(fetch_en), 1);

    // Memory wait for four cycles on M entry
    tick(3);
    mem_wait_i = 1'b1;
    #1 chk("mw_hold", 32'(mem_en), 0);
    tick(4);
    mem_wait_i = 1'b0;
    #1 chk("mw_commit", 32'(mem_en), 1);
    tick();
    #1 chk("mw_wb", 32'(wb_en), 1);
    tick();
    #1;
    chk("mw_9cyc_fetch", 32'(fetch_en), 1);
    chk("mw_stall", 32'(stall_cycles_o), 4);
    chk("mw_model_stall", m_stall, 4);
    chk("mw_retired", 32'(retired_o), 4);

    // UART store against busy transmitter for two cycles
    tick(3);
    uart_store_i = 1'b1; uart_busy_i = 1'b1;
    #1 chk("uart_hold", 32'(mem_en), 0);
    tick(2);
    uart_busy_i = 1'b0;
    #1 chk("uart_commit", 32'(mem_en), 1);
    tick(2);
    #1;
    chk("uart_stall", 32'(stall_cycles_o), 6);
    chk("uart_retired", 32'(retired_o), 5);
    tick(3);
    #1 chk("uart_idle_nostall", 32'(mem_en), 1);
    uart_store_i = 1'b0;
    tick(2);

    // Drop run mid-instruction: completes, then pauses
    tick();
    run_i = 1'b0;
    tick(4);
    #1;
    chk("drop_paused", 32'(stage_o), 5);
    chk("drop_retired", 32'(retired_o), 7);

    // Single step, second pulse mid-instruction ignored
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    tick(2);
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    tick(2);
    #1;
    chk("step1_paused", 32'(stage_o), 5);
    chk("step1_retired", 32'(retired_o), 8);
    tick(3);
    #1 chk("step1_idle", 32'(stage_o), 5);
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    tick(5);
    #1;
    chk("step2_paused", 32'(paused_o), 1);
    chk("step2_retired", 32'(retired_o), 9);

    // Run and step together: run wins, keeps going after W
    run_i = 1'b1; step_i = 1'b1;
    tick();
    step_i = 1'b0;
    tick(5);
    #1;
    chk("runstep_fetch", 32'(stage_o), 0);
    chk("runstep_retired", 32'(retired_o), 10);

    // Halt requested in E
    tick(2);
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    tick();
    #1 chk("halt_wb", 32'(wb_en), 1);
    tick();
    #1;
    chk("halt_state", 32'(stage_o), 6);
    chk("halt_flag", 32'(halted_o), 1);
    chk("halt_retired", 32'(retired_o), 11);
    for (int i = 0; i < 6; i++) begin
      run_i = i[0]; step_i = ~i[0];
      tick();
    end
    step_i = 1'b0; run_i = 1'b1;
    #1;
    chk("halt_sticky", 32'(halted_o), 1);
    chk("halt_enables", 32'({fetch_en, decode_en, exec_en, mem_en, wb_en}), 0);
    reset = 1'b1;
    #1;
    chk("halt_rst_stage", 32'(stage_o), 5);
    chk("halt_rst_ret", 32'(retired_o), 0);
    tick();
    reset = 1'b0;

    // Retired counter wrap at 4 bits
    tick(81);
    #1 chk("wrap16", 32'(retired_o), 0);
    tick(5);
    #1 chk("wrap17", 32'(retired_o), 1);

    // Reset during an M stall: enables drop immediately
    tick(3);
    mem_wait_i = 1'b1;
    tick(2);
    reset = 1'b1; mem_wait_i = 1'b0;
    #1;
    chk("rststall_mem_en", 32'(mem_en), 0);
    chk("rststall_stage", 32'(stage_o), 5);
    tick();
    reset = 1'b0;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      run_i        = ($urandom_range(0, 3) != 0);
      step_i       = ($urandom_range(0, 7) == 0);
      halt_i       = ($urandom_range(0, 49) == 0);
      mem_wait_i   = ($urandom_range(0, 2) == 0);
      uart_store_i = 1'($urandom_range(0, 1));
      uart_busy_i  = 1'($urandom_range(0, 1));
    end
    tick();
    reset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
